// File: rtl/mux8_sel_arbiter_pkg.sv
// Shared definitions for the 8:1 mux arbiter, its mux wrapper and its bench.
package mux8_sel_arbiter_pkg;

  localparam int unsigned ARB_N    = 8;
  localparam int unsigned ARB_SELW = 3;

  // Arbiter state encodings
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  typedef logic [ARB_N-1:0]    req_vec_t;
  typedef logic [ARB_SELW-1:0] sel_t;

  // One-hot decode of a select index
  function automatic req_vec_t sel_onehot(input sel_t s);
    return req_vec_t'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request searching from ptr upwards, wrapping modulo 8.
module rr_pick8
  import mux8_sel_arbiter_pkg::*;
(
  input  logic [ARB_N-1:0]    req,
  input  logic [ARB_SELW-1:0] ptr,
  output logic                found,
  output logic [ARB_SELW-1:0] idx
);

  logic [2*ARB_N-1:0] dbl;
  logic [ARB_N-1:0]   rot;
  sel_t               off;

  // Rotate so ptr lands on bit 0, priority-encode, then add ptr back
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[ARB_N-1:0];
    found = |rot;
    off   = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
    idx = off + ptr;
  end

endmodule

// File: rtl/mux8_sel_arbiter.sv
// Round-robin owner of an 8:1 mux select with bounded burst length.
// grant, sel and busy are all registered; sel only moves on a new grant so the
// mux output never glitches while idle.
module mux8_sel_arbiter
  import mux8_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ARB_N-1:0]    req,
  output logic [ARB_N-1:0]    grant,
  output logic [ARB_SELW-1:0] sel,
  output logic                busy
);

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  logic       state_q, state_d;
  sel_t       ptr_q, ptr_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  sel_t       sel_q, sel_d;
  req_vec_t   grant_q, grant_d;
  logic       busy_q, busy_d;

  logic       owner_req;
  req_vec_t   waiting;
  logic       release_c;
  logic       rotate_c;
  logic       take;
  req_vec_t   pick_mask;
  logic       pick_found;
  sel_t       pick_idx;

  // Release / forced-rotation decode and the request set offered to the picker
  always_comb begin
    owner_req = req[sel_q];
    waiting   = req & ~grant_q;
    release_c = (state_q == ST_OWN) && !owner_req;
    // Release wins over rotation because rotation requires the owner still requesting
    rotate_c  = (state_q == ST_OWN) && owner_req && (hold_cnt_q == HoldLast) && (|waiting);
    pick_mask = rotate_c ? waiting : req;
  end

  rr_pick8 u_pick (
    .req   (pick_mask),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state: new grant, drop to idle, or keep the current owner
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    take       = pick_found && ((state_q == ST_IDLE) || release_c || rotate_c);

    if (take) begin
      state_d    = ST_OWN;
      sel_d      = pick_idx;
      ptr_d      = pick_idx + 3'd1;
      hold_cnt_d = '0;
      busy_d     = 1'b1;
    end else if (release_c) begin
      // sel keeps its last value so the mux input stays put while idle
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else if (state_q == ST_OWN) begin
      // Saturate: a lone owner at the limit keeps the mux indefinitely
      if (hold_cnt_q != HoldLast) hold_cnt_d = hold_cnt_q + 4'd1;
    end

    grant_d = busy_d ? sel_onehot(sel_d) : '0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      sel_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule
